// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and the complex sample payload.
package fft_pkg;

    localparam int unsigned FFT_WIDTH = 9;
    localparam int unsigned FFT_DEPTH = 16;

    typedef struct packed {
        logic signed [FFT_WIDTH-1:0] re;
        logic signed [FFT_WIDTH-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample stream in, half-frame vectors out, between source, loader and butterfly.
interface fft_frame_loader_if
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = FFT_WIDTH,
    parameter int unsigned DEPTH = FFT_DEPTH
) ();

    logic                    s_valid;
    logic                    s_ready;
    logic signed [WIDTH-1:0] s_re;
    logic signed [WIDTH-1:0] s_im;
    logic                    s_last;

    logic signed [WIDTH-1:0] dout_R1 [DEPTH];
    logic signed [WIDTH-1:0] dout_R2 [DEPTH];
    logic signed [WIDTH-1:0] dout_Q1 [DEPTH];
    logic signed [WIDTH-1:0] dout_Q2 [DEPTH];
    logic                    out_valid;
    logic                    out_ready;
    logic                    frame_err;

    // Environment side: sample source plus butterfly consumer.
    modport master (
        output s_valid, s_re, s_im, s_last, out_ready,
        input  s_ready, dout_R1, dout_R2, dout_Q1, dout_Q2, out_valid, frame_err
    );

    modport slave (
        input  s_valid, s_re, s_im, s_last, out_ready,
        output s_ready, dout_R1, dout_R2, dout_Q1, dout_Q2, out_valid, frame_err
    );

endinterface

// File: rtl/fft_frame_bank.sv
// One frame bank: four DEPTH-entry signed register vectors, written one sample at a time.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = FFT_WIDTH,
    parameter int unsigned DEPTH = FFT_DEPTH,
    parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic                    hi,
    input  logic signed [WIDTH-1:0] re,
    input  logic signed [WIDTH-1:0] im,
    output logic signed [WIDTH-1:0] r1 [DEPTH],
    output logic signed [WIDTH-1:0] r2 [DEPTH],
    output logic signed [WIDTH-1:0] q1 [DEPTH],
    output logic signed [WIDTH-1:0] q2 [DEPTH]
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r1[i] <= '0;
                r2[i] <= '0;
                q1[i] <= '0;
                q2[i] <= '0;
            end
        end else if (we) begin
            if (hi) begin
                r2[idx] <= re;
                q2[idx] <= im;
            end else begin
                r1[idx] <= re;
                q1[idx] <= im;
            end
        end
    end

endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong frame loader: collects 2*DEPTH streamed samples per bank and presents
// a completed bank as four half-frame vectors to the first butterfly stage.
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = FFT_WIDTH,
    parameter int unsigned DEPTH = FFT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    fft_frame_loader_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(2 * DEPTH);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * DEPTH - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(DEPTH);

    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic             wr_sel;
    logic             rd_sel;
    logic [CNT_W-1:0] wr_cnt;
    logic             frame_err_q;

    logic             accept;
    logic             frame_done;
    logic             early_last;
    logic             consume;
    logic             wr_hi;
    logic [IDX_W-1:0] wr_idx;

    logic signed [WIDTH-1:0] bank_r1 [2][DEPTH];
    logic signed [WIDTH-1:0] bank_r2 [2][DEPTH];
    logic signed [WIDTH-1:0] bank_q1 [2][DEPTH];
    logic signed [WIDTH-1:0] bank_q2 [2][DEPTH];

    assign accept     = bus.s_valid && !full[wr_sel];
    assign frame_done = accept && (wr_cnt == LAST_CNT);
    assign early_last = accept && bus.s_last && !frame_done;
    assign consume    = full[rd_sel] && bus.out_ready;
    assign wr_hi      = (wr_cnt >= HALF_CNT);
    assign wr_idx     = wr_hi ? IDX_W'(wr_cnt - HALF_CNT) : IDX_W'(wr_cnt);

    // Completion and consumption always target different banks, so both may apply at once.
    always_comb begin
        full_nxt = full;
        if (consume) begin
            full_nxt[rd_sel] = 1'b0;
        end
        if (frame_done) begin
            full_nxt[wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full        <= 2'b00;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            wr_cnt      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            full        <= full_nxt;
            frame_err_q <= (frame_done && !bus.s_last) || early_last;
            if (accept) begin
                wr_cnt <= (frame_done || bus.s_last) ? '0 : wr_cnt + CNT_W'(1);
            end
            if (frame_done) begin
                wr_sel <= !wr_sel;
            end
            if (consume) begin
                rd_sel <= !rd_sel;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_frame_bank #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .IDX_W (IDX_W)
        ) u_bank (
            .clk (clk),
            .rst (rst),
            .we  (accept && (wr_sel == 1'(g))),
            .idx (wr_idx),
            .hi  (wr_hi),
            .re  (bus.s_re),
            .im  (bus.s_im),
            .r1  (bank_r1[g]),
            .r2  (bank_r2[g]),
            .q1  (bank_q1[g]),
            .q2  (bank_q2[g])
        );
    end

    // Present the read bank; consumers qualify the vectors with out_valid.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            bus.dout_R1[i] = bank_r1[rd_sel][i];
            bus.dout_R2[i] = bank_r2[rd_sel][i];
            bus.dout_Q1[i] = bank_q1[rd_sel][i];
            bus.dout_Q2[i] = bank_q2[rd_sel][i];
        end
    end

    assign bus.s_ready   = !full[wr_sel];
    assign bus.out_valid = full[rd_sel];
    assign bus.frame_err = frame_err_q;

endmodule
